sfp_vec_mul_pipe: RTL and testbench

- Pipelined, parametrised signed fixed-point vector multiplier.
- Computes N lane-wise products out[i] = a[i]*b[i] per accepted vector, over a STAGES-deep pipeline.
- Uses a valid/ready handshake and carries a sideband tag alongside each vector.
- Reports per-vector and sticky per-lane overflow flags.
- Successor to the combinational vector multiplier. It sits between the ray/vector datapath stages, which need back-pressure and known latency.

---
 rtl/sfp_vec_mul_pipe.sv | 180 ++++++++++++++++++
 tb/tb_sfp_vec_mul_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_vec_mul_pipe.sv
// Pipelined signed fixed-point vector multiplier with valid/ready flow control.
// Each lane computes a[i]*b[i] in Q(IW.QW), truncates toward -inf, then
// saturates or wraps to W bits, flagging overflow per lane. A sideband tag
// travels with every vector and a sticky per-lane overflow summary is kept.
module sfp_vec_mul_pipe #(
    parameter int N      = 3,
    parameter int IW     = 16,
    parameter int QW     = 16,
    parameter int CLIP   = 1,
    parameter int STAGES = 2,
    parameter int TAG_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*(IW+QW)-1:0]  in_a,
    input  logic [N*(IW+QW)-1:0]  in_b,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*(IW+QW)-1:0]  out_p,
    output logic [TAG_W-1:0]      out_tag,
    output logic [N-1:0]          out_clip,
    output logic [N-1:0]          clip_sticky,
    input  logic                  clip_clear
);

    localparam int W  = IW + QW;
    localparam int PW = 2 * W;

    // Full-precision signed product of two W-bit lanes.
    function automatic logic [PW-1:0] lane_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] be;
        ae = signed'({{W{a[W-1]}}, a});
        be = signed'({{W{b[W-1]}}, b});
        return ae * be;
    endfunction

    // Floor-shift a product back to Q(IW.QW) and reduce to W bits.
    // Returns {overflow, value}; overflow means the shifted value does not
    // fit, i.e. its top W+1 bits are not all copies of the sign.
    function automatic logic [W:0] lane_fix(input logic [PW-1:0] p);
        logic signed [PW-1:0] sh;
        logic [W:0]           hi;
        logic                 ovf;
        logic [W-1:0]         v;
        sh  = signed'(p) >>> QW;
        hi  = sh[PW-1:W-1];
        ovf = !((&hi) || !(|hi));
        if (ovf && (CLIP != 32'sd0)) begin
            v = sh[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            v = sh[W-1:0];
        end
        return {ovf, v};
    endfunction

    logic [N*PW-1:0]  fin_prod_s;
    logic [TAG_W-1:0] fin_tag_s;
    logic             fin_valid_s;
    logic [N*W-1:0]   fin_p_s;
    logic [N-1:0]     fin_clip_s;

    // Global stall: the whole pipe moves only when the output slot can drain.
    assign in_ready = out_ready || !out_valid;

    if (STAGES == 32'sd1) begin : g_comb
        // Single-stage build: multiply directly from the input operands.
        always_comb begin
            fin_prod_s = {(N*PW){1'b0}};
            for (int i = 0; i < N; i++) begin
                fin_prod_s[i*PW +: PW] = lane_mul(in_a[i*W +: W], in_b[i*W +: W]);
            end
        end
        assign fin_tag_s   = in_tag;
        assign fin_valid_s = in_valid;
    end else begin : g_pipe
        logic             s1_valid_r;
        logic [N*W-1:0]   s1_a_r;
        logic [N*W-1:0]   s1_b_r;
        logic [TAG_W-1:0] s1_tag_r;
        logic [N*PW-1:0]  s1_prod_s;

        // Operand capture stage.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_valid_r <= 1'b0;
                s1_a_r     <= {(N*W){1'b0}};
                s1_b_r     <= {(N*W){1'b0}};
                s1_tag_r   <= {TAG_W{1'b0}};
            end else if (in_ready) begin
                s1_valid_r <= in_valid;
                s1_a_r     <= in_a;
                s1_b_r     <= in_b;
                s1_tag_r   <= in_tag;
            end
        end

        // Lane products from the registered operands.
        always_comb begin
            s1_prod_s = {(N*PW){1'b0}};
            for (int i = 0; i < N; i++) begin
                s1_prod_s[i*PW +: PW] = lane_mul(s1_a_r[i*W +: W], s1_b_r[i*W +: W]);
            end
        end

        if (STAGES == 32'sd2) begin : g_direct
            assign fin_prod_s  = s1_prod_s;
            assign fin_tag_s   = s1_tag_r;
            assign fin_valid_s = s1_valid_r;
        end else begin : g_mid
            localparam int MD = STAGES - 2;
            logic [N*PW-1:0]  md_prod_r [MD];
            logic [TAG_W-1:0] md_tag_r  [MD];
            logic [MD-1:0]    md_valid_r;

            // Extra product stages so deeper pipes keep the multiplier off the final stage.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    md_valid_r <= {MD{1'b0}};
                    for (int k = 0; k < MD; k++) begin
                        md_prod_r[k] <= {(N*PW){1'b0}};
                        md_tag_r[k]  <= {TAG_W{1'b0}};
                    end
                end else if (in_ready) begin
                    md_valid_r[0] <= s1_valid_r;
                    md_prod_r[0]  <= s1_prod_s;
                    md_tag_r[0]   <= s1_tag_r;
                    for (int k = 1; k < MD; k++) begin
                        md_valid_r[k] <= md_valid_r[k-1];
                        md_prod_r[k]  <= md_prod_r[k-1];
                        md_tag_r[k]   <= md_tag_r[k-1];
                    end
                end
            end

            assign fin_prod_s  = md_prod_r[MD-1];
            assign fin_tag_s   = md_tag_r[MD-1];
            assign fin_valid_s = md_valid_r[MD-1];
        end
    end

    // Shift, saturate/wrap and overflow detection ahead of the output register.
    always_comb begin
        fin_p_s    = {(N*W){1'b0}};
        fin_clip_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            {fin_clip_s[i], fin_p_s[i*W +: W]} = lane_fix(fin_prod_s[i*PW +: PW]);
        end
    end

    // Output stage; holds its contents while downstream stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_p     <= {(N*W){1'b0}};
            out_tag   <= {TAG_W{1'b0}};
            out_clip  <= {N{1'b0}};
        end else if (in_ready) begin
            out_valid <= fin_valid_s;
            out_p     <= fin_p_s;
            out_tag   <= fin_tag_s;
            out_clip  <= fin_clip_s;
        end
    end

    // Sticky overflow summary; a new overflow transfer beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clip_sticky <= {N{1'b0}};
        end else if (out_valid && out_ready) begin
            clip_sticky <= (clip_clear ? {N{1'b0}} : clip_sticky) | out_clip;
        end else if (clip_clear) begin
            clip_sticky <= {N{1'b0}};
        end
    end

endmodule

// File: tb/tb_sfp_vec_mul_pipe.sv
// Scoreboard bench: a saturating 2-stage instance and a wrapping 3-stage
// instance share stimulus; expected lanes come from 64-bit integer arithmetic.
`timescale 1ns/1ps
module tb_sfp_vec_mul_pipe;
    localparam int N = 3, IW = 16, QW = 16, W = 32, TW = 8;

    logic clk = 1'b0;
    logic rst_n, in_valid, out_ready, clip_clear;
    logic [N*W-1:0] in_a, in_b;
    logic [TW-1:0]  in_tag;
    logic ir0, ov0, ir1, ov1;
    logic [N*W-1:0] p0, p1;
    logic [TW-1:0]  t0, t1;
    logic [N-1:0]   c0, c1, s0, s1;

    sfp_vec_mul_pipe #(.N(N), .IW(IW), .QW(QW), .CLIP(1), .STAGES(2), .TAG_W(TW)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(ov0), .out_ready(out_ready),
        .out_p(p0), .out_tag(t0), .out_clip(c0), .clip_sticky(s0), .clip_clear(clip_clear));

    sfp_vec_mul_pipe #(.N(N), .IW(IW), .QW(QW), .CLIP(0), .STAGES(3), .TAG_W(TW)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(ov1), .out_ready(out_ready),
        .out_p(p1), .out_tag(t1), .out_clip(c1), .clip_sticky(s1), .clip_clear(clip_clear));

    always #5 clk = ~clk;

    typedef struct {
        logic [N*W-1:0] p;
        logic [N-1:0]   clip;
        logic [TW-1:0]  tag;
        int             cyc;
        int             stl;
    } item_t;

    item_t q0[$];
    item_t q1[$];
    int n_tests = 0, n_fail = 0, cyc = 0;
    int stall [2];
    logic [N-1:0]   ms [2];
    logic           hold_v [2];
    logic [N*W-1:0] hold_p [2];
    logic [TW-1:0]  hold_t [2];
    logic [N-1:0]   hold_c [2];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference lane: exact 64-bit product, floor division by 2^QW, range test.
    function automatic logic [W:0] ref_lane(input logic [W-1:0] a, input logic [W-1:0] b, input bit sat);
        longint pa, pb, sh, hi_lim, lo_lim;
        logic [W-1:0] r;
        bit ov;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        sh = (pa * pb) >>> QW;
        hi_lim = (64'sd1 <<< (W-1)) - 64'sd1;
        lo_lim = -(64'sd1 <<< (W-1));
        ov = (sh > hi_lim) || (sh < lo_lim);
        if (ov && sat) r = (sh < 0) ? hi_lim[W-1:0] + 32'd1 : hi_lim[W-1:0];
        else r = sh[W-1:0];
        return {ov, r};
    endfunction

    function automatic item_t mk(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                 input logic [TW-1:0] t, input bit sat);
        item_t it;
        logic [W:0] r;
        it.p = '0; it.clip = '0; it.tag = t; it.cyc = 0; it.stl = 0;
        for (int i = 0; i < N; i++) begin
            r = ref_lane(a[i*W +: W], b[i*W +: W], sat);
            it.p[i*W +: W] = r[W-1:0];
            it.clip[i] = r[W];
        end
        return it;
    endfunction

    // Per-DUT monitor, stability/sticky model and acceptance capture at one negedge.
    task automatic dut_side(input int d, input logic ov, input logic [N*W-1:0] p, input logic [TW-1:0] t,
                            input logic [N-1:0] c, input logic [N-1:0] s, input logic ir);
        item_t it;
        logic [N-1:0] setv;
        int exp_lat;
        setv = '0;
        chk($sformatf("sticky%0d", d), s, ms[d]);
        if (hold_v[d]) begin
            chk($sformatf("stall_valid%0d", d), ov, 1'b1);
            chk($sformatf("stall_p%0d", d), p, hold_p[d]);
            chk($sformatf("stall_tag%0d", d), t, hold_t[d]);
            chk($sformatf("stall_clip%0d", d), c, hold_c[d]);
        end
        if (ov && out_ready) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_out%0d: actual tag=%0h required no output", d, t);
            end else begin
                if (d == 0) it = q0.pop_front(); else it = q1.pop_front();
                exp_lat = ((d == 0) ? 2 : 3) + stall[d] - it.stl;
                chk($sformatf("p%0d", d), p, it.p);
                chk($sformatf("tag%0d", d), t, it.tag);
                chk($sformatf("clip%0d", d), c, it.clip);
                chk($sformatf("latency%0d", d), cyc - it.cyc, exp_lat);
                setv = it.clip;
            end
        end
        hold_v[d] = ov && !out_ready;
        hold_p[d] = p; hold_t[d] = t; hold_c[d] = c;
        ms[d] = (clip_clear ? '0 : ms[d]) | setv;
        if (in_valid && ir) begin
            it = mk(in_a, in_b, in_tag, d == 0);
            it.cyc = cyc; it.stl = stall[d];
            if (d == 0) q0.push_back(it); else q1.push_back(it);
        end
        if (!ir) stall[d]++;
    endtask

    // Scoreboard process: everything is sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            q0.delete(); q1.delete();
            for (int d = 0; d < 2; d++) begin ms[d] = '0; hold_v[d] = 1'b0; end
        end else begin
            dut_side(0, ov0, p0, t0, c0, s0, ir0);
            dut_side(1, ov1, p1, t1, c1, s1, ir1);
        end
    end

    function automatic logic [W-1:0] rnd_small();
        logic [W-1:0] v;
        v = $urandom;
        return {{16{v[15]}}, v[15:0]};
    endfunction

    function automatic logic [W-1:0] rnd_lane();
        logic [W-1:0] v;
        logic [W-1:0] sp [6];
        sp[0] = 32'h7FFFFFFF; sp[1] = 32'h80000000; sp[2] = 32'hFFFFFFFF;
        sp[3] = 32'h00010000; sp[4] = 32'h00000000; sp[5] = 32'hFFFF0000;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: return v;
            1: return {{12{v[19]}}, v[19:0]};
            2: return sp[$urandom_range(0, 5)];
            default: return {{8{v[23]}}, v[23:0]};
        endcase
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [N*W-1:0] a, input logic [N*W-1:0] b, input logic [TW-1:0] t);
        int k;
        step();
        in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!ir0 && k < 20) begin @(negedge clk); k++; end
        if (!ir0) begin n_tests++; n_fail++; $display("FAIL send_timeout: actual in_ready=0 required 1"); end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_v(input int d);
        int k;
        k = 0;
        @(negedge clk);
        while (((d == 0) ? !ov0 : !ov1) && k < 10) begin @(negedge clk); k++; end
        if ((d == 0) ? !ov0 : !ov1) begin
            n_tests++; n_fail++;
            $display("FAIL wait_out%0d: actual out_valid=0 required 1", d);
        end
    endtask

    logic [W-1:0] da [6], db [6], dsat [6], dwrap [6];
    logic         dclip [6];

    initial begin
        int idx, k;
        logic [N*W-1:0] va [10];
        logic [N*W-1:0] vb [10];
        da[0] = 32'h00018000; db[0] = 32'h00020000; dsat[0] = 32'h00030000; dwrap[0] = 32'h00030000; dclip[0] = 1'b0;
        da[1] = 32'hFFFF0000; db[1] = 32'h00008000; dsat[1] = 32'hFFFF8000; dwrap[1] = 32'hFFFF8000; dclip[1] = 1'b0;
        da[2] = 32'h00000001; db[2] = 32'h00000001; dsat[2] = 32'h00000000; dwrap[2] = 32'h00000000; dclip[2] = 1'b0;
        da[3] = 32'hFFFFFFFF; db[3] = 32'h00000001; dsat[3] = 32'hFFFFFFFF; dwrap[3] = 32'hFFFFFFFF; dclip[3] = 1'b0;
        da[4] = 32'h7FFF0000; db[4] = 32'h00020000; dsat[4] = 32'h7FFFFFFF; dwrap[4] = 32'hFFFE0000; dclip[4] = 1'b1;
        da[5] = 32'h80000000; db[5] = 32'h00020000; dsat[5] = 32'h80000000; dwrap[5] = 32'h00000000; dclip[5] = 1'b1;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clip_clear = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid0", ov0, 1'b0);
        chk("rst_out_valid1", ov1, 1'b0);
        chk("rst_out_p0", p0, '0);
        chk("rst_out_tag0", t0, '0);
        chk("rst_out_clip0", c0, '0);
        chk("rst_sticky0", s0, '0);
        chk("rst_in_ready0", ir0, 1'b1);
        chk("rst_in_ready1", ir1, 1'b1);

        // Directed arithmetic corners on lane 0, small random values elsewhere.
        for (int i = 0; i < 6; i++) begin
            send({rnd_small(), rnd_small(), da[i]}, {rnd_small(), rnd_small(), db[i]}, 8'(8'h10 + i));
            wait_v(0);
            chk($sformatf("dir%0d_sat_p", i), p0[W-1:0], dsat[i]);
            chk($sformatf("dir%0d_sat_clip", i), c0[0], dclip[i]);
            chk($sformatf("dir%0d_sat_tag", i), t0, 8'(8'h10 + i));
            wait_v(1);
            chk($sformatf("dir%0d_wrap_p", i), p1[W-1:0], dwrap[i]);
            chk($sformatf("dir%0d_wrap_clip", i), c1[0], dclip[i]);
        end

        // Clear pulse with nothing transferring.
        step(); clip_clear = 1'b1;
        step(); clip_clear = 1'b0;
        @(negedge clk);
        chk("clear_sticky0", s0, '0);
        chk("clear_sticky1", s1, '0);

        // Clear held across an overflow transfer: the new overflow must survive.
        clip_clear = 1'b1;
        send({rnd_small(), rnd_small(), da[4]}, {rnd_small(), rnd_small(), db[4]}, 8'h2A);
        wait_v(0);
        step(); clip_clear = 1'b0;
        @(negedge clk);
        chk("set_wins_sticky0", s0[0], 1'b1);
        repeat (4) step();

        // Back-pressure: out_ready low for stream cycles 3..7.
        for (int i = 0; i < 10; i++) begin
            va[i] = {rnd_lane(), rnd_lane(), rnd_lane()};
            vb[i] = {rnd_lane(), rnd_lane(), rnd_lane()};
        end
        idx = 0; k = 0;
        while (idx < 10 && k < 40) begin
            step();
            out_ready = !(k >= 3 && k <= 7);
            in_valid = 1'b1; in_a = va[idx]; in_b = vb[idx]; in_tag = 8'(8'h40 + idx);
            @(negedge clk);
            chk($sformatf("bp_in_ready_k%0d", k), ir0, !(k >= 3 && k <= 7));
            if (ir0) idx++;
            k++;
        end
        step(); in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) step();

        // Reset with two vectors in flight.
        in_valid = 1'b1; in_a = {rnd_small(), rnd_small(), rnd_small()}; in_b = in_a; in_tag = 8'hA1;
        step(); in_tag = 8'hA2;
        step(); in_valid = 1'b0; rst_n = 1'b0;
        step(); rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid0", ov0, 1'b0);
        chk("midrst_out_valid1", ov1, 1'b0);
        chk("midrst_sticky0", s0, '0);
        chk("midrst_sticky1", s1, '0);
        send({rnd_small(), rnd_small(), da[0]}, {rnd_small(), rnd_small(), db[0]}, 8'hB7);
        wait_v(0);
        chk("postrst_tag0", t0, 8'hB7);
        chk("postrst_p0", p0[W-1:0], dsat[0]);
        repeat (4) step();

        // Randomized traffic with random back-pressure and clears.
        for (int n = 0; n < 400; n++) begin
            step();
            in_valid   = ($urandom_range(0, 9) < 7);
            in_a       = {rnd_lane(), rnd_lane(), rnd_lane()};
            in_b       = {rnd_lane(), rnd_lane(), rnd_lane()};
            in_tag     = 8'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            clip_clear = ($urandom_range(0, 19) == 0);
        end
        step(); in_valid = 1'b0; out_ready = 1'b1; clip_clear = 1'b0;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 20) begin step(); k++; end
        @(negedge clk);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
